// File: rtl/block_ram_be_clr.sv
`default_nettype none
// ============================================================================
// Module      : block_ram_be_clr
// Description : Single-port block RAM with byte-lane write enables, selectable
//               read-during-write result, optional output register stage and
//               a hardware clear engine that sweeps every word.
// Revision    : 1.0 - initial release
// ============================================================================
module block_ram_be_clr #(
  parameter int                       ADDR_WIDTH   = 10,
  parameter int                       LANE_WIDTH   = 8,
  parameter int                       NUM_LANES    = 4,
  parameter int                       RDW_MODE     = 0,
  parameter int                       OUT_REG      = 0,
  parameter int                       CLR_ON_RESET = 1,
  parameter logic [LANE_WIDTH-1:0]    CLR_VALUE    = '0,
  localparam int                      DATA_WIDTH   = LANE_WIDTH * NUM_LANES
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DATA_WIDTH-1:0] DI,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic                  WE,
  input  logic                  RE,
  input  logic [NUM_LANES-1:0]  BE,
  input  logic                  CLR,
  output logic                  BUSY,
  output logic [DATA_WIDTH-1:0] DO,
  output logic                  DO_VALID
);

  localparam int                    C_DEPTH       = 1 << ADDR_WIDTH;
  localparam logic [0:0]            C_ST_IDLE     = 1'b0;
  localparam logic [0:0]            C_ST_CLEARING = 1'b1;
  localparam logic [0:0]            C_ST_RESET    = (CLR_ON_RESET != 0) ? C_ST_CLEARING : C_ST_IDLE;
  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR   = '1;
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE    = 1;
  localparam logic [DATA_WIDTH-1:0] C_CLR_WORD    = {NUM_LANES{CLR_VALUE}};

  // Storage array; contents are deliberately not reset (block RAM friendly).
  logic [DATA_WIDTH-1:0] r_mem [C_DEPTH];

  logic [0:0]            r_state;
  logic [0:0]            w_state_next;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  w_idle;
  logic                  w_clearing;
  logic                  w_clr_last;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_rd_merged;
  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;

  // State register; reset lands in CLEARING when an automatic sweep is wanted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= C_ST_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: CLR only honoured in IDLE, sweep ends after the last word.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      C_ST_IDLE:     if (CLR)        w_state_next = C_ST_CLEARING;
      C_ST_CLEARING: if (w_clr_last) w_state_next = C_ST_IDLE;
      default:                       w_state_next = C_ST_IDLE;
    endcase
  end

  // State decode: all user traffic is gated off while the sweep runs.
  always_comb begin
    w_idle     = (r_state == C_ST_IDLE);
    w_clearing = (r_state == C_ST_CLEARING);
    w_clr_last = w_clearing && (r_clr_cnt == C_LAST_ADDR);
    w_wr_acc   = w_idle && WE;
    w_rd_acc   = w_idle && RE;
  end

  assign BUSY = w_clearing;

  // Sweep address counter; wraps back to zero as the last word is written.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_clr_cnt <= '0;
    end else if (w_clearing) begin
      r_clr_cnt <= r_clr_cnt + C_ADDR_ONE;
    end
  end

  // Array write port: sweep word or lane-masked user write.
  always_ff @(posedge CLK) begin
    if (w_clearing) begin
      r_mem[r_clr_cnt] <= C_CLR_WORD;
    end else if (w_wr_acc) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (BE[b]) begin
          r_mem[ADDR][b*LANE_WIDTH +: LANE_WIDTH] <= DI[b*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  assign w_rd_word = r_mem[ADDR];

  // Read-during-write merge: in new-data mode enabled lanes forward DI.
  always_comb begin
    w_rd_merged = w_rd_word;
    if ((RDW_MODE != 0) && WE) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (BE[b]) begin
          w_rd_merged[b*LANE_WIDTH +: LANE_WIDTH] = DI[b*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // First read stage; data holds when no read is accepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_s1_data <= w_rd_merged;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  r_s2_valid;
      logic [DATA_WIDTH-1:0] r_s2_data;

      // Second read stage adds one cycle of latency, still one read per cycle.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign DO       = r_s2_data;
      assign DO_VALID = r_s2_valid;
    end else begin : g_no_out_reg
      assign DO       = r_s1_data;
      assign DO_VALID = r_s1_valid;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_block_ram_be_clr.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_ram_be_clr
// Description : Scoreboard bench for block_ram_be_clr. Two instances share the
//               stimulus: A = old-data RDW, latency 1, clear value 0;
//               B = new-data RDW, latency 2, clear value 8'hA5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_ram_be_clr;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   di = '0;
  logic [AW-1:0] addr = '0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [3:0]    be = '0;
  logic          clr = 1'b0;
  logic          busy_a, busy_b, dv_a, dv_b;
  logic [31:0]   do_a, do_b;

  int            cyc = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  logic [31:0]   mem_a [DEPTH];
  logic [31:0]   mem_b [DEPTH];
  exp_t          q_a [$];
  exp_t          q_b [$];

  block_ram_be_clr #(
    .ADDR_WIDTH(AW), .LANE_WIDTH(8), .NUM_LANES(4), .RDW_MODE(0), .OUT_REG(0),
    .CLR_ON_RESET(1), .CLR_VALUE(8'h00)
  ) dut_a (
    .CLK(clk), .RST_N(rst_n), .DI(di), .ADDR(addr), .WE(we), .RE(re), .BE(be),
    .CLR(clr), .BUSY(busy_a), .DO(do_a), .DO_VALID(dv_a)
  );

  block_ram_be_clr #(
    .ADDR_WIDTH(AW), .LANE_WIDTH(8), .NUM_LANES(4), .RDW_MODE(1), .OUT_REG(1),
    .CLR_ON_RESET(1), .CLR_VALUE(8'hA5)
  ) dut_b (
    .CLK(clk), .RST_N(rst_n), .DI(di), .ADDR(addr), .WE(we), .RE(re), .BE(be),
    .CLR(clr), .BUSY(busy_b), .DO(do_b), .DO_VALID(dv_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: pop and compare when a DUT raises its valid strobe.
  always @(posedge clk) begin : sb_monitor
    exp_t e;
    #1;
    while (q_a.size() > 0 && q_a[0].due < cyc) begin
      chk("a_missing_valid", 32'd0, 32'd1);
      void'(q_a.pop_front());
    end
    if (dv_a) begin
      if (q_a.size() == 0) chk("a_spurious_valid", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        chk("a_do", do_a, e.data);
        chk("a_latency", cyc, e.due);
      end
    end
    while (q_b.size() > 0 && q_b[0].due < cyc) begin
      chk("b_missing_valid", 32'd0, 32'd1);
      void'(q_b.pop_front());
    end
    if (dv_b) begin
      if (q_b.size() == 0) chk("b_spurious_valid", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        chk("b_do", do_b, e.data);
        chk("b_latency", cyc, e.due);
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 32'h0000_0000;
      mem_b[i] = 32'hA5A5_A5A5;
    end
  endtask

  // One IDLE-state operation, driven at the falling edge; model tracks it.
  task automatic op(input logic w, input logic r, input logic c, input logic [AW-1:0] a,
                    input logic [31:0] d, input logic [3:0] bmask);
    exp_t        e;
    logic [31:0] merged;
    @(negedge clk);
    we = w; re = r; clr = c; addr = a; di = d; be = bmask;
    if (r) begin
      e.data = mem_a[a];
      e.due  = cyc + 1;
      q_a.push_back(e);
      merged = mem_b[a];
      if (w) for (int l = 0; l < 4; l++) if (bmask[l]) merged[l*8 +: 8] = d[l*8 +: 8];
      e.data = merged;
      e.due  = cyc + 2;
      q_b.push_back(e);
    end
    if (w) begin
      for (int l = 0; l < 4; l++) begin
        if (bmask[l]) begin
          mem_a[a][l*8 +: 8] = d[l*8 +: 8];
          mem_b[a][l*8 +: 8] = d[l*8 +: 8];
        end
      end
    end
  endtask

  task automatic idle_inputs();
    we = 1'b0; re = 1'b0; clr = 1'b0; be = '0; di = '0; addr = '0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy_a && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    idle_inputs();
  endtask

  initial begin : main
    int n;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy_a", {31'd0, busy_a}, 32'd1);
    chk("reset_busy_b", {31'd0, busy_b}, 32'd1);
    chk("reset_dv_a", {31'd0, dv_a}, 32'd0);
    chk("reset_dv_b", {31'd0, dv_b}, 32'd0);
    chk("reset_do_a", do_a, 32'd0);
    chk("reset_do_b", do_b, 32'd0);

    // Automatic sweep after reset release
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n);
    chk("reset_sweep_cycles", n, DEPTH);
    chk("busy_b_low", {31'd0, busy_b}, 32'd0);
    model_clear();

    // Cleared contents
    op(0, 1, 0, 0, 0, 0);
    op(0, 1, 0, 7, 0, 0);
    op(0, 1, 0, 15, 0, 0);

    // Partial lane write over a cleared word
    op(1, 0, 0, 3, 32'hAABBCCDD, 4'b0101);
    op(0, 1, 0, 3, 0, 0);

    // Read-during-write on addr 5, then read back
    op(1, 0, 0, 5, 32'h11223344, 4'b1111);
    op(1, 1, 0, 5, 32'hFFFFFFFF, 4'b1100);
    op(0, 1, 0, 5, 0, 0);

    // WE with no lanes enabled is a no-op
    op(1, 0, 0, 5, 32'h0BAD0BAD, 4'b0000);
    op(0, 1, 0, 5, 0, 0);

    // Back-to-back reads
    op(0, 1, 0, 0, 0, 0);
    op(0, 1, 0, 1, 0, 0);
    op(0, 1, 0, 2, 0, 0);

    // Mixed random traffic
    for (int i = 0; i < 40; i++) begin
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, AW'($urandom_range(0, DEPTH-1)),
         $urandom, 4'($urandom_range(0, 15)));
    end
    repeat (3) op(0, 0, 0, 0, 0, 0);

    // CLR pulse with a read in the same cycle, then hammer inputs during sweep
    op(0, 1, 1, 3, 0, 0);
    @(posedge clk); #1;
    chk("clr_busy_start", {31'd0, busy_a}, 32'd1);
    n = 0;
    while (busy_a && n < 200) begin
      @(negedge clk);
      we = 1'b1; re = 1'b1; clr = 1'b1; be = 4'hF;
      di = $urandom; addr = AW'($urandom_range(0, DEPTH-1));
      @(posedge clk); #1;
      n++;
    end
    idle_inputs();
    chk("clr_sweep_cycles", n, DEPTH);
    model_clear();
    for (int i = 0; i < DEPTH; i++) op(0, 1, 0, AW'(i), 0, 0);
    repeat (3) op(0, 0, 0, 0, 0, 0);

    // Reset in the middle of a sweep restarts it from word 0
    for (int i = 0; i < DEPTH; i++) op(1, 0, 0, AW'(i), {4{8'(i + 8'h30)}} ^ 32'h0F0F_0F0F, 4'hF);
    op(0, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    idle_inputs();
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midsweep_reset_busy", {31'd0, busy_a}, 32'd1);
    chk("midsweep_reset_dv", {31'd0, dv_b}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_busy(n);
    chk("restart_sweep_cycles", n, DEPTH);
    model_clear();
    for (int i = 0; i < DEPTH; i++) op(0, 1, 0, AW'(i), 0, 0);
    repeat (4) op(0, 0, 0, 0, 0, 0);

    chk("sb_drained_a", q_a.size(), 32'd0);
    chk("sb_drained_b", q_b.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
